// File: rtl/md5_pkg.sv
// Shared MD5 constants, state encoding and message-schedule helper for the
// compression engine and its step datapath.
package md5_pkg;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] K [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotate amounts, indexed [round][step mod 4].
    localparam logic [4:0] S [0:3][0:3] = '{
        '{5'd7, 5'd12, 5'd17, 5'd22},
        '{5'd5, 5'd9,  5'd14, 5'd20},
        '{5'd4, 5'd11, 5'd16, 5'd23},
        '{5'd6, 5'd10, 5'd15, 5'd21}
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Message word used by step j; all index arithmetic is mod 16.
    function automatic logic [3:0] msg_idx(input logic [5:0] j);
        logic [3:0] lo;
        logic [3:0] g;
        lo = j[3:0];
        case (j[5:4])
            2'd0:    g = lo;
            2'd1:    g = lo * 4'd5 + 4'd1;
            2'd2:    g = lo * 4'd3 + 4'd5;
            default: g = lo * 4'd7;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: round function, four-input add, rotate and the
// (a,b,c,d) register rotation.
module md5_step
    import md5_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] m_i,
    input  logic [31:0] k_i,
    input  logic [4:0]  s_i,
    input  logic [1:0]  round_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [31:0] w_f;
    logic [31:0] w_t;
    logic [63:0] w_rot64;

    always_comb begin
        w_f = '0;
        case (round_i)
            2'd0:    w_f = (b_i & c_i) | (~b_i & d_i);
            2'd1:    w_f = (b_i & d_i) | (c_i & ~d_i);
            2'd2:    w_f = b_i ^ c_i ^ d_i;
            default: w_f = c_i ^ (b_i | ~d_i);
        endcase
    end

    assign w_t = a_i + k_i + m_i + w_f;
    // Doubling the word turns the rotate into a plain shift of the upper half.
    assign w_rot64 = {w_t, w_t} << s_i;

    assign a_o = d_i;
    assign b_o = b_i + w_rot64[63:32];
    assign c_o = b_i;
    assign d_o = c_i;

endmodule

// File: rtl/md5_compress_engine.sv
// MD5 compression engine: buffers one 512-bit block, runs 64 steps at
// STEPS_PER_CYCLE per clock and returns the chained 128-bit state.
module md5_compress_engine
    import md5_pkg::*;
#(
    parameter int N               = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [N-1:0] M_i [0:15],
    input  logic         init_i,
    output logic         dig_valid_o,
    input  logic         dig_ready_i,
    output logic [N-1:0] A_o,
    output logic [N-1:0] B_o,
    output logic [N-1:0] C_o,
    output logic [N-1:0] D_o,
    output logic         busy_o,
    output logic [1:0]   state_o
);

    localparam int SPC = STEPS_PER_CYCLE;
    localparam logic [5:0] LAST_STEP = 6'(64 - SPC);

    state_e       r_state;
    logic [5:0]   r_step;
    logic [N-1:0] r_m [0:15];
    logic [N-1:0] r_ha, r_hb, r_hc, r_hd;
    logic [N-1:0] r_a, r_b, r_c, r_d;
    logic [N-1:0] r_da, r_db, r_dc, r_dd;

    logic [N-1:0] w_a [0:SPC];
    logic [N-1:0] w_b [0:SPC];
    logic [N-1:0] w_c [0:SPC];
    logic [N-1:0] w_d [0:SPC];
    logic [N-1:0] w_base_a, w_base_b, w_base_c, w_base_d;

    assign w_a[0] = r_a;
    assign w_b[0] = r_b;
    assign w_c[0] = r_c;
    assign w_d[0] = r_d;

    for (genvar i = 0; i < SPC; i++) begin : g_step
        logic [5:0] w_j;
        assign w_j = r_step + 6'(i);
        md5_step u_step (
            .a_i     (w_a[i]),
            .b_i     (w_b[i]),
            .c_i     (w_c[i]),
            .d_i     (w_d[i]),
            .m_i     (r_m[msg_idx(w_j)]),
            .k_i     (K[w_j]),
            .s_i     (S[w_j[5:4]][w_j[1:0]]),
            .round_i (w_j[5:4]),
            .a_o     (w_a[i+1]),
            .b_o     (w_b[i+1]),
            .c_o     (w_c[i+1]),
            .d_o     (w_d[i+1])
        );
    end

    // The held digest doubles as chaining state; it resets to the IV.
    assign w_base_a = init_i ? IV_A : r_da;
    assign w_base_b = init_i ? IV_B : r_db;
    assign w_base_c = init_i ? IV_C : r_dc;
    assign w_base_d = init_i ? IV_D : r_dd;

    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the producer holds valid and data until then.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_m     <= '{default: '0};
            r_ha    <= IV_A;
            r_hb    <= IV_B;
            r_hc    <= IV_C;
            r_hd    <= IV_D;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_da    <= IV_A;
            r_db    <= IV_B;
            r_dc    <= IV_C;
            r_dd    <= IV_D;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (blk_valid_i) begin
                        r_m     <= M_i;
                        r_ha    <= w_base_a;
                        r_hb    <= w_base_b;
                        r_hc    <= w_base_c;
                        r_hd    <= w_base_d;
                        r_a     <= w_base_a;
                        r_b     <= w_base_b;
                        r_c     <= w_base_c;
                        r_d     <= w_base_d;
                        r_step  <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a    <= w_a[SPC];
                    r_b    <= w_b[SPC];
                    r_c    <= w_c[SPC];
                    r_d    <= w_d[SPC];
                    r_step <= r_step + 6'(SPC);
                    if (r_step == LAST_STEP) begin
                        r_da    <= r_ha + w_a[SPC];
                        r_db    <= r_hb + w_b[SPC];
                        r_dc    <= r_hc + w_c[SPC];
                        r_dd    <= r_hd + w_d[SPC];
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (dig_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign blk_ready_o = (r_state == ST_IDLE);
    assign dig_valid_o = (r_state == ST_DONE);
    assign busy_o      = (r_state != ST_IDLE);
    assign state_o     = r_state;
    assign A_o         = r_da;
    assign B_o         = r_db;
    assign C_o         = r_dc;
    assign D_o         = r_dd;

endmodule

// File: tb/tb_md5_compress_engine.sv
// Bench for md5_compress_engine at 1, 2 and 4 steps per cycle: known-answer
// table, random blocks against a textbook MD5 model, and handshake corner cases.
module tb_md5_compress_engine;

    localparam logic [127:0] IV_ALL = 128'h67452301_efcdab89_98badcfe_10325476;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m_in [16];
    logic        init;
    logic        blk_valid [3];
    logic        blk_ready [3];
    logic        dig_valid [3];
    logic        dig_ready [3];
    logic        busy      [3];
    logic [31:0] a_o [3], b_o [3], c_o [3], d_o [3];
    logic [1:0]  st  [3];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    md5_compress_engine #(.N(32), .STEPS_PER_CYCLE(1)) u_spc1 (
        .clk_i(clk), .rst_i(rst_n), .blk_valid_i(blk_valid[0]), .blk_ready_o(blk_ready[0]),
        .M_i(m_in), .init_i(init), .dig_valid_o(dig_valid[0]), .dig_ready_i(dig_ready[0]),
        .A_o(a_o[0]), .B_o(b_o[0]), .C_o(c_o[0]), .D_o(d_o[0]), .busy_o(busy[0]), .state_o(st[0]));
    md5_compress_engine #(.N(32), .STEPS_PER_CYCLE(2)) u_spc2 (
        .clk_i(clk), .rst_i(rst_n), .blk_valid_i(blk_valid[1]), .blk_ready_o(blk_ready[1]),
        .M_i(m_in), .init_i(init), .dig_valid_o(dig_valid[1]), .dig_ready_i(dig_ready[1]),
        .A_o(a_o[1]), .B_o(b_o[1]), .C_o(c_o[1]), .D_o(d_o[1]), .busy_o(busy[1]), .state_o(st[1]));
    md5_compress_engine #(.N(32), .STEPS_PER_CYCLE(4)) u_spc4 (
        .clk_i(clk), .rst_i(rst_n), .blk_valid_i(blk_valid[2]), .blk_ready_o(blk_ready[2]),
        .M_i(m_in), .init_i(init), .dig_valid_o(dig_valid[2]), .dig_ready_i(dig_ready[2]),
        .A_o(a_o[2]), .B_o(b_o[2]), .C_o(c_o[2]), .D_o(d_o[2]), .busy_o(busy[2]), .state_o(st[2]));

    int checks = 0;
    int failures = 0;
    logic [31:0]  kt [64];
    logic [127:0] chain [3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference MD5 compression, straight from the algorithm description.
    function automatic logic [127:0] md5_model(input logic [127:0] h, input logic [31:0] m [16]);
        int sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
        logic [31:0] a, b, c, d, f, t, tmp;
        int g, s;
        a = h[127:96]; b = h[95:64]; c = h[63:32]; d = h[31:0];
        for (int j = 0; j < 64; j++) begin
            if (j < 16)      begin f = (b & c) | (~b & d); g = j;               end
            else if (j < 32) begin f = (d & b) | (~d & c); g = (5 * j + 1) % 16; end
            else if (j < 48) begin f = b ^ c ^ d;          g = (3 * j + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * j) % 16;     end
            s = sh[(j / 16) * 4 + (j % 4)];
            t = a + kt[j] + m[g] + f;
            tmp = d; d = c; c = b;
            b = b + ((t << s) | (t >> (32 - s)));
            a = tmp;
        end
        return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
    endfunction

    function automatic logic [127:0] dig_of(input int u);
        return {a_o[u], b_o[u], c_o[u], d_o[u]};
    endfunction

    task automatic accept(input int u, input logic ini, input logic [31:0] m [16]);
        int n = 0;
        @(negedge clk);
        while (!blk_ready[u] && n < 200) begin @(negedge clk); n++; end
        check($sformatf("accept_ready_u%0d", u), {127'b0, blk_ready[u]}, 128'd1);
        m_in = m; init = ini; blk_valid[u] = 1'b1;
        @(negedge clk);
        blk_valid[u] = 1'b0;
        // The engine must work from its own copy of the block.
        for (int i = 0; i < 16; i++) m_in[i] = $urandom;
        init = 1'($urandom_range(0, 1));
    endtask

    // Counts rising edges after the accepting edge; cycle index = edges + 1.
    task automatic wait_valid(input int u, output int lat);
        int n = 0;
        while (!dig_valid[u] && n < 200) begin @(negedge clk); n++; end
        if (!dig_valid[u]) begin
            failures++; checks++;
            $display("FAIL wait_valid_u%0d: dig_valid not seen within 200 cycles", u);
        end
        lat = n + 1;
    endtask

    task automatic take(input int u, output logic [127:0] dig);
        dig = dig_of(u);
        dig_ready[u] = 1'b1;
        @(negedge clk);
        dig_ready[u] = 1'b0;
        check($sformatf("post_handshake_u%0d", u), {126'b0, dig_valid[u], blk_ready[u]}, 128'b01);
    endtask

    task automatic do_block(input int u, input logic ini, input logic [31:0] m [16],
                            output logic [127:0] dig, output int lat);
        accept(u, ini, m);
        wait_valid(u, lat);
        take(u, dig);
    endtask

    task automatic check_reset_outputs(input string name, input int u);
        check({name, "_flags"}, {123'b0, blk_ready[u], dig_valid[u], busy[u], st[u]}, 128'b10000);
        check({name, "_digest"}, dig_of(u), IV_ALL);
    endtask

    typedef struct {
        string        name;
        logic         init;
        logic [31:0]  m [16];
        logic [127:0] exp;
        logic         use_const;
    } vec_t;

    vec_t vt [4];

    initial begin
        logic [31:0]  m [16];
        logic [31:0]  m_abc [16];
        logic [127:0] dig, exp, snap;
        int           lat, bad, nacc;
        int           t_acc [3];
        real          r;

        for (int i = 0; i < 64; i++) begin
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            kt[i] = 32'(longint'($floor(r * 4294967296.0)));
        end

        // Clock/reset
        rst_n = 1'b0;
        init = 1'b0;
        m_in = '{default: 32'h0};
        for (int u = 0; u < 3; u++) begin
            blk_valid[u] = 1'b0; dig_ready[u] = 1'b0; chain[u] = IV_ALL;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) check_reset_outputs($sformatf("reset_u%0d", u), u);

        // Known-answer table
        m_abc = '{default: 32'h0};
        m_abc[0] = 32'h80636261; m_abc[14] = 32'h00000018;
        vt[0].name = "empty"; vt[0].init = 1'b1; vt[0].m = '{default: 32'h0}; vt[0].m[0] = 32'h00000080;
        vt[0].exp = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec; vt[0].use_const = 1'b1;
        vt[1].name = "abc"; vt[1].init = 1'b1; vt[1].m = m_abc;
        vt[1].exp = 128'h98500190_b04fd23c_7d3f96d6_727fe128; vt[1].use_const = 1'b1;
        vt[2].name = "a64_blk1"; vt[2].init = 1'b1; vt[2].m = '{default: 32'h61616161};
        vt[2].exp = '0; vt[2].use_const = 1'b0;
        vt[3].name = "a64_blk2"; vt[3].init = 1'b0; vt[3].m = '{default: 32'h0};
        vt[3].m[0] = 32'h00000080; vt[3].m[14] = 32'h00000200;
        vt[3].exp = 128'hd4424801_4971b580_63034a5a_67733f79; vt[3].use_const = 1'b1;

        for (int i = 0; i < 4; i++) begin
            exp = md5_model(vt[i].init ? IV_ALL : chain[0], vt[i].m);
            do_block(0, vt[i].init, vt[i].m, dig, lat);
            if (vt[i].use_const) check(vt[i].name, dig, vt[i].exp);
            else begin
                check(vt[i].name, dig, exp);
                check({vt[i].name, "_not_iv"}, {127'b0, dig == IV_ALL}, 128'd0);
            end
            check({vt[i].name, "_latency"}, lat, 65);
            chain[0] = exp;
        end

        for (int u = 1; u < 3; u++) begin
            do_block(u, 1'b1, m_abc, dig, lat);
            check($sformatf("abc_u%0d", u), dig, 128'h98500190_b04fd23c_7d3f96d6_727fe128);
            check($sformatf("abc_latency_u%0d", u), lat, (u == 1) ? 33 : 17);
            chain[u] = dig;
        end

        // Random blocks, chained or fresh, against the model
        for (int k = 0; k < 12; k++) begin
            int u;
            logic ini;
            u = (k < 6) ? 0 : (k < 9) ? 1 : 2;
            ini = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 16; i++) m[i] = $urandom;
            exp = md5_model(ini ? IV_ALL : chain[u], m);
            chain[u] = exp;
            do_block(u, ini, m, dig, lat);
            check($sformatf("rand%0d_u%0d_init%0d", k, u, ini), dig, exp);
            check($sformatf("rand%0d_latency", k), lat, 64 / (1 << u) + 1);
        end

        // Backpressure: digest held, new block ignored, then released
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        exp = md5_model(chain[0], m);
        chain[0] = exp;
        accept(0, 1'b0, m);
        wait_valid(0, lat);
        snap = dig_of(0);
        bad = 0;
        for (int i = 0; i < 16; i++) m_in[i] = $urandom;
        init = 1'b1;
        blk_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dig_of(0) !== snap || blk_ready[0] !== 1'b0 || dig_valid[0] !== 1'b1) bad++;
        end
        blk_valid[0] = 1'b0;
        check("bp_stable_cycles_bad", bad, 0);
        take(0, dig);
        check("bp_digest", dig, exp);
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        exp = md5_model(chain[0], m);
        chain[0] = exp;
        do_block(0, 1'b0, m, dig, lat);
        check("bp_chain_after_ignored", dig, exp);

        // Asynchronous reset mid-RUN, then chain-from-reset gives the IV start
        accept(0, 1'b1, m_abc);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrun_reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int u = 0; u < 3; u++) chain[u] = IV_ALL;
        @(negedge clk);
        check_reset_outputs("after_reset", 0);
        do_block(0, 1'b0, m_abc, dig, lat);
        check("abc_after_reset_init0", dig, 128'h98500190_b04fd23c_7d3f96d6_727fe128);

        // Back-to-back blocks with valid and ready held high
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        exp = md5_model(IV_ALL, m);
        @(negedge clk);
        m_in = m; init = 1'b1;
        blk_valid[0] = 1'b1; dig_ready[0] = 1'b1;
        nacc = 0; bad = 0;
        for (int c = 0; c < 400 && nacc < 3; c++) begin
            if (blk_ready[0]) begin t_acc[nacc] = cyc; nacc++; end
            if (dig_valid[0] && dig_of(0) !== exp) bad++;
            @(negedge clk);
        end
        blk_valid[0] = 1'b0;
        check("b2b_accepts", nacc, 3);
        check("b2b_digest_bad", bad, 0);
        if (nacc == 3) begin
            check("b2b_period_1", t_acc[1] - t_acc[0], 66);
            check("b2b_period_2", t_acc[2] - t_acc[1], 66);
        end
        wait_valid(0, lat);
        check("b2b_last_digest", dig_of(0), exp);
        @(negedge clk);
        dig_ready[0] = 1'b0;
        chain[0] = exp;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
